// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// FSM state encoding and the instruction classes the decoder produces.
package ctrl_pkg;

  localparam logic [4:0] PC_INC_CODE  = 5'b11111;
  localparam logic [4:0] ALU_ADD_CODE = 5'b00011;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_e;

  typedef enum logic [3:0] {
    CL_LOAD, CL_LOADI, CL_STORE, CL_ALU_R, CL_ALU_I, CL_MULDIV, CL_UNARY,
    CL_BRANCH, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_e;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between control_unit (master) and DataPath (slave):
// IR/condition flowing up, load/drive enables and strobes flowing down.
interface control_unit_if;
  logic [31:0] ir;
  logic        ConOut;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic Gra, Grb, Grc, RIn, ROut, BAOut;
  logic Conin, memread, memwrite, run;
  logic [4:0] ALUCode;

  modport master (
    input  ir, ConOut,
    output HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
           HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
           Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run, ALUCode
  );

  modport slave (
    output ir, ConOut,
    input  HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
           HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
           Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run, ALUCode
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the ALU code used by
// the execute step that computes (address/branch arithmetic defaults to add).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_e    iclass_o,
  output logic [4:0] alu_code_o
);

  always_comb begin
    iclass_o   = CL_NOP;
    alu_code_o = ALU_ADD_CODE;
    case (opcode_i)
      OP_LD:   iclass_o = CL_LOAD;
      OP_LDI:  iclass_o = CL_LOADI;
      OP_ST:   iclass_o = CL_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
        iclass_o   = CL_ALU_R;
        alu_code_o = opcode_i;
      end
      // Immediate forms reuse the ALU operation of their register twin
      OP_ADDI: begin iclass_o = CL_ALU_I; alu_code_o = OP_ADD; end
      OP_ANDI: begin iclass_o = CL_ALU_I; alu_code_o = OP_AND; end
      OP_ORI:  begin iclass_o = CL_ALU_I; alu_code_o = OP_OR;  end
      OP_MUL, OP_DIV: begin
        iclass_o   = CL_MULDIV;
        alu_code_o = opcode_i;
      end
      OP_NEG, OP_NOT: begin
        iclass_o   = CL_UNARY;
        alu_code_o = opcode_i;
      end
      OP_BR:   iclass_o = CL_BRANCH;
      OP_JR:   iclass_o = CL_JR;
      OP_IN:   iclass_o = CL_IN;
      OP_OUT:  iclass_o = CL_OUT;
      OP_MFHI: iclass_o = CL_MFHI;
      OP_MFLO: iclass_o = CL_MFLO;
      OP_HALT: iclass_o = CL_HALT;
      default: iclass_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control FSM: fetch T0-T2, class-dependent execute T3-T7, Moore
// outputs per state (branch PCIn additionally gated by ConOut in T6).
module control_unit
  import ctrl_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [4:0] alu_code;
  logic       unused_ir;

  ctrl_decode u_decode (
    .opcode_i   (cu.ir[31:27]),
    .iclass_o   (iclass),
    .alu_code_o (alu_code)
  );

  // Operand fields of IR are consumed by DataPath, not by the sequencer
  assign unused_ir = ^cu.ir[26:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET: state_d = T0;
      T0:    state_d = T1;
      T1:    state_d = T2;
      T2:    state_d = T3;
      T3: begin
        case (iclass)
          CL_HALT: state_d = HALTED;
          CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP: state_d = T0;
          default: state_d = T4;
        endcase
      end
      T4:     state_d = (iclass == CL_UNARY) ? T0 : T5;
      T5:     state_d = (iclass inside {CL_LOADI, CL_ALU_R, CL_ALU_I}) ? T0 : T6;
      T6:     state_d = (iclass inside {CL_MULDIV, CL_BRANCH}) ? T0 : T7;
      T7:     state_d = T0;
      HALTED: state_d = HALTED;
      default: state_d = RESET;
    endcase
  end

  always_comb begin
    {cu.HiIn, cu.LoIn, cu.ZIn, cu.PCIn, cu.MDRIn, cu.MARIn, cu.YIn, cu.OPortIn, cu.IRIn} = '0;
    {cu.HiOut, cu.LoOut, cu.ZHiOut, cu.ZLoOut, cu.PCOut, cu.MDROut, cu.IPortOut, cu.COut} = '0;
    {cu.Gra, cu.Grb, cu.Grc, cu.RIn, cu.ROut, cu.BAOut} = '0;
    {cu.Conin, cu.memread, cu.memwrite} = '0;
    cu.ALUCode = '0;
    cu.run     = (state_q != RESET) && (state_q != HALTED);
    case (state_q)
      T0: begin cu.PCOut = 1'b1; cu.MARIn = 1'b1; cu.ZIn = 1'b1; cu.ALUCode = PC_INC_CODE; end
      T1: begin cu.ZLoOut = 1'b1; cu.PCIn = 1'b1; cu.memread = 1'b1; cu.MDRIn = 1'b1; end
      T2: begin cu.MDROut = 1'b1; cu.IRIn = 1'b1; end
      T3: begin
        case (iclass)
          CL_LOAD, CL_LOADI, CL_STORE: begin cu.Grb = 1'b1; cu.BAOut = 1'b1; cu.YIn = 1'b1; end
          CL_ALU_R, CL_ALU_I:          begin cu.Grb = 1'b1; cu.ROut = 1'b1; cu.YIn = 1'b1; end
          CL_MULDIV:                   begin cu.Gra = 1'b1; cu.ROut = 1'b1; cu.YIn = 1'b1; end
          CL_UNARY: begin
            cu.Grb = 1'b1; cu.ROut = 1'b1; cu.ZIn = 1'b1; cu.ALUCode = alu_code;
          end
          CL_BRANCH: begin cu.Gra = 1'b1; cu.ROut = 1'b1; cu.Conin = 1'b1; end
          CL_JR:     begin cu.Gra = 1'b1; cu.ROut = 1'b1; cu.PCIn = 1'b1; end
          CL_IN:     begin cu.IPortOut = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1; end
          CL_OUT:    begin cu.Gra = 1'b1; cu.ROut = 1'b1; cu.OPortIn = 1'b1; end
          CL_MFHI:   begin cu.HiOut = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1; end
          CL_MFLO:   begin cu.LoOut = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1; end
          default:   ;
        endcase
      end
      T4: begin
        case (iclass)
          CL_LOAD, CL_LOADI, CL_STORE, CL_ALU_I: begin
            cu.COut = 1'b1; cu.ZIn = 1'b1; cu.ALUCode = alu_code;
          end
          CL_ALU_R:  begin cu.Grc = 1'b1; cu.ROut = 1'b1; cu.ZIn = 1'b1; cu.ALUCode = alu_code; end
          CL_MULDIV: begin cu.Grb = 1'b1; cu.ROut = 1'b1; cu.ZIn = 1'b1; cu.ALUCode = alu_code; end
          CL_UNARY:  begin cu.ZLoOut = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1; end
          CL_BRANCH: begin cu.PCOut = 1'b1; cu.YIn = 1'b1; end
          default:   ;
        endcase
      end
      T5: begin
        case (iclass)
          CL_LOAD, CL_STORE:             begin cu.ZLoOut = 1'b1; cu.MARIn = 1'b1; end
          CL_LOADI, CL_ALU_R, CL_ALU_I:  begin cu.ZLoOut = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1; end
          CL_MULDIV:                     begin cu.ZLoOut = 1'b1; cu.LoIn = 1'b1; end
          CL_BRANCH: begin cu.COut = 1'b1; cu.ZIn = 1'b1; cu.ALUCode = alu_code; end
          default:   ;
        endcase
      end
      T6: begin
        case (iclass)
          CL_LOAD:   begin cu.memread = 1'b1; cu.MDRIn = 1'b1; end
          CL_STORE:  begin cu.Gra = 1'b1; cu.ROut = 1'b1; cu.MDRIn = 1'b1; end
          CL_MULDIV: begin cu.ZHiOut = 1'b1; cu.HiIn = 1'b1; end
          CL_BRANCH: begin cu.ZLoOut = 1'b1; cu.PCIn = cu.ConOut; end
          default:   ;
        endcase
      end
      T7: begin
        if (iclass == CL_LOAD)  begin cu.MDROut = 1'b1; cu.Gra = 1'b1; cu.RIn = 1'b1; end
        if (iclass == CL_STORE) cu.memwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
